// File: rtl/dac_playback_ctrl_if.sv
// Config/control port and DAC FIFO link of the playback sequencer.
// The master modport is the sequencer side; slave is the surrounding system.
interface dac_playback_ctrl_if #(
    parameter int unsigned DW     = 10,
    parameter int unsigned MEM_AW = 6
);
    logic              cfg_we;
    logic [MEM_AW-1:0] cfg_addr;
    logic [DW-1:0]     cfg_wdata;
    logic [MEM_AW-1:0] start_addr;
    logic [MEM_AW-1:0] end_addr;
    logic [7:0]        loop_count;
    logic              start;
    logic              stop;
    logic              underrun_clr;
    logic              fifo_low;
    logic              fifo_empty;
    logic              dac_wr;
    logic [DW-1:0]     dac_data;
    logic              dac_en;
    logic              busy;
    logic              done;
    logic              underrun;

    modport master (
        input  cfg_we, cfg_addr, cfg_wdata, start_addr, end_addr, loop_count,
               start, stop, underrun_clr, fifo_low, fifo_empty,
        output dac_wr, dac_data, dac_en, busy, done, underrun
    );

    modport slave (
        output cfg_we, cfg_addr, cfg_wdata, start_addr, end_addr, loop_count,
               start, stop, underrun_clr, fifo_low, fifo_empty,
        input  dac_wr, dac_data, dac_en, busy, done, underrun
    );
endinterface

// File: rtl/dac_playback_ctrl.sv
// Streams [start_addr..end_addr] of a small pattern RAM into the DAC sample FIFO
// in bursts, N passes or forever, with sticky underrun detection.
module dac_playback_ctrl #(
    parameter int unsigned DW     = 10,
    parameter int unsigned MEM_AW = 6,
    parameter int unsigned BURST  = 4
) (
    input logic                clk,
    input logic                rst_n,
    dac_playback_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, FILL, WAIT, DRAIN, DONE} state_t;

    localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;

    state_t            state, state_d;
    logic [DW-1:0]     mem [2**MEM_AW];
    logic [MEM_AW-1:0] ptr, start_r, end_r;
    logic [7:0]        loops_r, loop_ctr;
    logic [BW-1:0]     burst_ctr;
    logic              dac_wr_r;
    logic [DW-1:0]     dac_data_r;
    logic              underrun_r;

    logic accept, do_write, set_ur, at_end, last_pass, burst_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        do_write   = 1'b0;
        set_ur     = 1'b0;
        at_end     = (ptr == end_r);
        last_pass  = (loops_r != '0) && ((loop_ctr + 8'd1) == loops_r);
        burst_full = (burst_ctr == BW'(BURST - 1));
        unique case (state)
            IDLE: begin
                if (bus.start && (bus.start_addr <= bus.end_addr)) begin
                    accept  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.stop) begin
                    state_d = DRAIN;
                end else begin
                    do_write = 1'b1;
                    if (at_end && last_pass) state_d = DRAIN;
                    else if (burst_full)     state_d = WAIT;
                end
            end
            WAIT: begin
                set_ur = bus.fifo_empty;
                if (bus.stop)          state_d = DRAIN;
                else if (bus.fifo_low) state_d = FILL;
            end
            DRAIN: begin
                if (bus.fifo_empty) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pattern RAM is not reset; a read on the same edge as a write sees the old word.
    always_ff @(posedge clk) begin
        if (bus.cfg_we) mem[bus.cfg_addr] <= bus.cfg_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            start_r    <= '0;
            end_r      <= '0;
            loops_r    <= '0;
            loop_ctr   <= '0;
            burst_ctr  <= '0;
            dac_wr_r   <= 1'b0;
            dac_data_r <= '0;
            underrun_r <= 1'b0;
        end else begin
            dac_wr_r <= do_write;
            if (accept) begin
                start_r   <= bus.start_addr;
                end_r     <= bus.end_addr;
                loops_r   <= bus.loop_count;
                ptr       <= bus.start_addr;
                loop_ctr  <= '0;
                burst_ctr <= '0;
            end
            if (do_write) begin
                dac_data_r <= mem[ptr];
                // Counter wraps at the burst boundary, so WAIT->FILL always starts from zero.
                burst_ctr  <= burst_full ? '0 : burst_ctr + BW'(1);
                if (at_end) begin
                    ptr      <= start_r;
                    loop_ctr <= loop_ctr + 8'd1;
                end else begin
                    ptr <= ptr + MEM_AW'(1);
                end
            end
            if (set_ur)                         underrun_r <= 1'b1;
            else if (accept || bus.underrun_clr) underrun_r <= 1'b0;
        end
    end

    assign bus.dac_wr   = dac_wr_r;
    assign bus.dac_data = dac_data_r;
    assign bus.dac_en   = (state != IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.underrun = underrun_r;
endmodule
